// File: rtl/counter_pkg.sv
// Shared types for the tick/timebase counters.
package counter_pkg;
  localparam int CNT_W = 8;
  typedef logic [CNT_W-1:0] cnt_t;
endpackage

// File: rtl/tick_counter.sv
// Free-running modulo-n_ticks counter with a one-cycle terminal strobe.
// No handshakes: data_o/watch_o are valid every cycle, and downstream samples on watch_o.
module tick_counter
  import counter_pkg::*;
#(
  parameter int WIDTH = CNT_W
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic [WIDTH-1:0] n_ticks,
  output logic [WIDTH-1:0] data_o,
  output logic             watch_o
);

  logic [WIDTH-1:0] cnt, cnt_n;
  logic [WIDTH-1:0] lim, lim_n;
  logic             watch, watch_n;
  logic             terminal;

  // The lim != 0 guard keeps lim - 1 from underflowing.
  assign terminal = (lim != '0) && (cnt == lim - 1'b1);

  always_comb begin
    cnt_n   = cnt + 1'b1;
    lim_n   = lim;
    watch_n = 1'b0;
    if (rstn || (lim == '0)) begin
      cnt_n = '0;
      lim_n = n_ticks;
    end else begin
      if (terminal) begin
        cnt_n = '0;
        lim_n = n_ticks;
      end
      // Strobe is registered, so it is derived from next-state values.
      watch_n = (lim_n != '0) && (cnt_n == lim_n - 1'b1);
    end
  end

  always_ff @(posedge clk) begin
    cnt   <= cnt_n;
    lim   <= lim_n;
    watch <= watch_n;
  end

  assign data_o  = cnt;
  assign watch_o = watch;

endmodule

// File: tb/tb_tick_counter.sv
// Randomized and directed bench for tick_counter with a queued scoreboard.
module tb_tick_counter;
  import counter_pkg::*;

  logic       clk_tb;
  logic       rstn;
  logic [7:0] n_ticks;
  logic [7:0] data_o;
  logic       watch_o;

  int tests_run = 0;
  int tests_failed = 0;

  logic [8:0] exp_q[$];

  // Reference model: current period, phase within it, strobe.
  int m_p = 0;
  int m_k = 0;
  int m_w = 0;

  tick_counter #(.WIDTH(8)) dut (
    .clk     (clk_tb),
    .rstn    (rstn),
    .n_ticks (n_ticks),
    .data_o  (data_o),
    .watch_o (watch_o)
  );

  initial clk_tb = 1'b0;
  always #5 clk_tb = ~clk_tb;

  // One clock edge with the given inputs; the model follows the spec rules.
  task automatic step(input logic r, input logic [7:0] n);
    rstn    = r;
    n_ticks = n;
    @(posedge clk_tb);
    if (r || m_p == 0) begin
      m_k = 0;
      m_p = int'(n);
      m_w = 0;
    end else begin
      m_k = (m_k + 1) % m_p;
      if (m_k == 0) m_p = int'(n);
      m_w = (m_p != 0 && m_k == m_p - 1) ? 1 : 0;
    end
    exp_q.push_back({m_w[0], m_k[7:0]});
    @(negedge clk_tb);
  endtask

  task automatic run(input int cycles, input logic [7:0] n);
    for (int i = 0; i < cycles; i++) step(1'b0, n);
  endtask

  task automatic run_until(input int target, input logic [7:0] n, input string tag);
    int guard;
    guard = 0;
    while (m_k != target && guard < 600) begin
      step(1'b0, n);
      guard++;
    end
    tests_run++;
    if (m_k != target) begin
      tests_failed++;
      $display("FAIL %s: model phase %0d, required %0d within budget", tag, m_k, target);
    end
  endtask

  // Monitor: outputs are valid every cycle once an edge has been modelled.
  always @(negedge clk_tb) begin
    logic [8:0] e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      tests_run++;
      if ({watch_o, data_o} !== e) begin
        tests_failed++;
        $display("FAIL cycle_check t=%0t: data_o=%0d watch_o=%0b, required data_o=%0d watch_o=%0b",
                 $time, data_o, watch_o, e[7:0], e[8]);
      end
    end
  end

  initial begin
    rstn    = 1'b1;
    n_ticks = 8'd100;
    step(1'b1, 8'd100);
    step(1'b1, 8'd100);

    // Period 100 with wrap.
    run(250, 8'd100);

    // n_ticks = 1 after a fresh reset.
    step(1'b1, 8'd1);
    run(10, 8'd1);

    // Parked, then period 3.
    step(1'b1, 8'd0);
    run(10, 8'd0);
    run(12, 8'd3);

    // Mid-period change: 10 -> 5 at data_o == 4.
    step(1'b1, 8'd10);
    run_until(4, 8'd10, "reach_4");
    run(25, 8'd5);

    // Reset mid-operation at data_o == 7.
    step(1'b1, 8'd10);
    run_until(7, 8'd10, "reach_7");
    step(1'b1, 8'd10);
    run(25, 8'd10);

    // Maximum period.
    step(1'b1, 8'd255);
    run(600, 8'd255);

    // Random periods and changes, occasional reset.
    for (int i = 0; i < 3000; i++) begin
      logic [7:0] n;
      if ($urandom_range(0, 3) == 0) n = 8'($urandom_range(0, 3));
      else n = 8'($urandom_range(0, 20));
      step(($urandom_range(0, 99) == 0) ? 1'b1 : 1'b0, n);
    end

    @(negedge clk_tb);
    tests_run++;
    if (exp_q.size() != 0) begin
      tests_failed++;
      $display("FAIL queue_drain: %0d entries left, required 0", exp_q.size());
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
